// File: rtl/data_memory_sync.sv
// ---------------------------------------------------------------------------
// data_memory_sync
//   Clocked data memory for the CPU MEM stage. Synchronous writes, 1-cycle
//   registered reads with a valid strobe, an address-bypass read path
//   (Memtoreg=0), and an out-of-range error pulse. After reset an init
//   sequencer walks every word, loading the preset table
//   (20,5,15,7,18,3,19,8) into words 0..7 when PRELOAD=1 and zero elsewhere.
//
//   Optional build macro: DMEM_WR_FWD_EN
//     defined     : read+write to the same in-range word in one cycle returns
//                   Datawrite (write-first forwarding)
//     not defined : the same case returns the pre-write word
//
// Ports
//   Clk        in   clock, rising edge
//   Rst        in   synchronous active-high reset
//   Memread    in   read request (honoured only while Ready=1)
//   Memwrite   in   write request (honoured only while Ready=1)
//   Memtoreg   in   0: read returns addr, 1: read returns memory word
//   addr       in   word address [ADDR_W]
//   Datawrite  in   write data [DATA_W]
//   Readdata   out  registered read data, holds until the next read
//   Rvalid     out  1-cycle pulse, Readdata updated
//   Ready      out  init complete, requests accepted
//   Err        out  1-cycle pulse, accepted request had addr >= DEPTH
// ---------------------------------------------------------------------------
module data_memory_sync #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PRELOAD = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Memread,
    input  logic              Memwrite,
    input  logic              Memtoreg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Datawrite,
    output logic [DATA_W-1:0] Readdata,
    output logic              Rvalid,
    output logic              Ready,
    output logic              Err
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_LAST = DEPTH - 1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               rvalid_d;
    logic               err_d;
    logic               ready_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic [IDX_W-1:0]   idx;
    logic               in_range;
    logic               fwd_hit;

    assign idx      = addr[IDX_W-1:0];
    // In range only when every address bit above the index is zero.
    assign in_range = ((addr >> IDX_W) == '0);

    // Same-cycle read+write always targets the same word (single address port).
`ifdef DMEM_WR_FWD_EN
    assign fwd_hit  = Memwrite && in_range;
`else
    assign fwd_hit  = 1'b0;
`endif

    // Init value for word i: preset table entry or zero.
    function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] i);
        logic [DATA_W-1:0] w;
        w = '0;
        if (PRELOAD != 0 && 32'(i) < 32'd8) begin
            case (3'(i))
                3'd0:    w = DATA_W'(20);
                3'd1:    w = DATA_W'(5);
                3'd2:    w = DATA_W'(15);
                3'd3:    w = DATA_W'(7);
                3'd4:    w = DATA_W'(18);
                3'd5:    w = DATA_W'(3);
                3'd6:    w = DATA_W'(19);
                default: w = DATA_W'(8);
            endcase
        end
        return w;
    endfunction

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            Readdata <= '0;
            Rvalid   <= 1'b0;
            Ready    <= 1'b0;
            Err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            Readdata <= rdata_d;
            Rvalid   <= rvalid_d;
            Ready    <= ready_d;
            Err      <= err_d;
        end
    end

    // Next-state, memory write port and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = Readdata;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = init_word(cnt_q);
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(CNT_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Memwrite && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx;
                    mem_wdata = Datawrite;
                end
                if (Memread) begin
                    rvalid_d = 1'b1;
                    if (!Memtoreg) begin
                        rdata_d = DATA_W'(addr);
                    end else if (!in_range) begin
                        rdata_d = '0;
                    end else if (fwd_hit) begin
                        rdata_d = Datawrite;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
                // Bypass reads never flag; a read+write miss still gives one pulse.
                err_d = !in_range && (Memwrite || (Memread && Memtoreg));
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        ready_d = (state_d == S_RUN);
    end

    // Storage array; reset does not clear it, the init sequencer does.
    always_ff @(posedge Clk) begin
        if (!Rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_sync.sv
module tb_data_memory_sync;

`ifdef DMEM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Memread;
    logic        Memwrite;
    logic        Memtoreg;
    logic [15:0] addr;
    logic [15:0] Datawrite;
    logic [15:0] Readdata;
    logic        Rvalid;
    logic        Ready;
    logic        Err;

    data_memory_sync #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (16),
        .PRELOAD(1)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Memread  (Memread),
        .Memwrite (Memwrite),
        .Memtoreg (Memtoreg),
        .addr     (addr),
        .Datawrite(Datawrite),
        .Readdata (Readdata),
        .Rvalid   (Rvalid),
        .Ready    (Ready),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int          preset [8] = '{20, 5, 15, 7, 18, 3, 19, 8};
    logic [15:0] mm [16];
    int          m_cnt = 0;
    bit          m_ready = 1'b0;
    logic [15:0] m_rdata = '0;
    bit          m_rvalid = 1'b0;
    bit          m_err = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input bit rst, input bit rd, input bit wr, input bit m2r,
                        input logic [15:0] a, input logic [15:0] d);
        bit inr;
        Rst = rst; Memread = rd; Memwrite = wr; Memtoreg = m2r;
        addr = a; Datawrite = d;
        @(posedge Clk);
        #1;
        if (rst) begin
            m_cnt = 0; m_ready = 0; m_rdata = '0; m_rvalid = 0; m_err = 0;
        end else if (!m_ready) begin
            mm[m_cnt] = (m_cnt < 8) ? 16'(preset[m_cnt]) : 16'h0000;
            m_cnt++;
            if (m_cnt == 16) m_ready = 1;
            m_rvalid = 0; m_err = 0;
        end else begin
            inr = (a < 16);
            m_rvalid = rd;
            m_err = !inr && (wr || (rd && m2r));
            if (rd) begin
                if (!m2r)            m_rdata = a;
                else if (!inr)       m_rdata = 16'h0000;
                else if (wr && FWD)  m_rdata = d;
                else                 m_rdata = mm[a[3:0]];
            end
            if (wr && inr) mm[a[3:0]] = d;
        end
        chk("mdl_ready",  16'(Ready),  16'(m_ready));
        chk("mdl_rvalid", 16'(Rvalid), 16'(m_rvalid));
        chk("mdl_err",    16'(Err),    16'(m_err));
        chk("mdl_rdata",  Readdata,    m_rdata);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        bit          m2r;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] er;
        bit          ev;
        bit          ee;
    } vec_t;

    vec_t tbl[$];

    initial begin
        Rst = 1'b1; Memread = 1'b0; Memwrite = 1'b0; Memtoreg = 1'b0;
        addr = '0; Datawrite = '0;

        // Preset reads, then boundary word 8
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1, 0, 1, 16'(i), 16'h0, 16'(preset[i]), 1, 0});
        tbl.push_back('{1, 0, 1, 16'd8,  16'h0,    16'h0000, 1, 0});
        // Write then read back
        tbl.push_back('{0, 1, 0, 16'd3,  16'h1234, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 1, 16'd3,  16'h0,    16'h1234, 1, 0});
        // Same-cycle read+write, then re-read
        tbl.push_back('{1, 1, 1, 16'd5,  16'hBEEF, FWD ? 16'hBEEF : 16'h0003, 1, 0});
        tbl.push_back('{1, 0, 1, 16'd5,  16'h0,    16'hBEEF, 1, 0});
        // Out-of-range write: no alias onto word 0
        tbl.push_back('{0, 1, 1, 16'd16, 16'hFFFF, 16'hBEEF, 0, 1});
        tbl.push_back('{1, 0, 1, 16'd0,  16'h0,    16'd20,   1, 0});
        tbl.push_back('{1, 0, 1, 16'd20, 16'h0,    16'h0000, 1, 1});
        // Address bypass never flags
        tbl.push_back('{1, 0, 0, 16'h0042, 16'h0, 16'h0042, 1, 0});
        tbl.push_back('{1, 0, 0, 16'h0100, 16'h0, 16'h0100, 1, 0});
        // Idle holds data
        tbl.push_back('{0, 0, 1, 16'd1,  16'h0,    16'h0100, 0, 0});
        // Read+write both out of range: single Err pulse, then clear
        tbl.push_back('{1, 1, 1, 16'd16, 16'h7777, 16'h0000, 1, 1});
        tbl.push_back('{0, 0, 0, 16'd0,  16'h0,    16'h0000, 0, 0});

        // Reset and init: requests during init must be ignored
        step(1, 0, 0, 0, 16'h0, 16'h0);
        chk("rst_ready",  16'(Ready),  16'h0);
        chk("rst_rvalid", 16'(Rvalid), 16'h0);
        chk("rst_rdata",  Readdata,    16'h0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 1, 16'(i), 16'hDEAD);
            chk("init_ready", 16'(Ready), (i == 15) ? 16'h1 : 16'h0);
            chk("init_rvalid", 16'(Rvalid), 16'h0);
        end

        foreach (tbl[k]) begin
            step(0, tbl[k].rd, tbl[k].wr, tbl[k].m2r, tbl[k].a, tbl[k].d);
            chk("tbl_rdata",  Readdata,          tbl[k].er);
            chk("tbl_rvalid", 16'(Rvalid),       16'(tbl[k].ev));
            chk("tbl_err",    16'(Err),          16'(tbl[k].ee));
        end

        // Reset with a read pending: read dropped, memory re-initialised
        step(0, 0, 1, 1, 16'd2, 16'h00AA);
        step(1, 1, 0, 1, 16'd2, 16'h0);
        chk("rst_mid_rvalid", 16'(Rvalid), 16'h0);
        chk("rst_mid_ready",  16'(Ready),  16'h0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 16'h0, 16'h0);
            chk("reinit_ready", 16'(Ready), (i == 15) ? 16'h1 : 16'h0);
        end
        step(0, 1, 0, 1, 16'd2, 16'h0);
        chk("reinit_rd2", Readdata, 16'd15);
        chk("reinit_rv",  16'(Rvalid), 16'h1);

        // Randomised traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 16'($urandom_range(0, 15));
            else if (sel < 9) a = 16'($urandom_range(16, 63));
            else              a = 16'($urandom);
            step(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), a, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
